event_pacing_scheduler: RTL and testbench
=========================================

EVENT_PACING_SCHEDULER -- requirements
Module: event_pacing_scheduler

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1000, meaning cycles between periodic deadlines (min 2).
REQ-002 SHALL have parameter DEPTH, default 4, meaning event-queue entries (power of 2, min 2).
REQ-003 SHALL have parameter TS_WIDTH, default 32, meaning timestamp width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  enable; when 0, all state frozen and no push/pop.
REQ-007 new_input_0 / new_input_1  in  1 each  input-event strobes, one cycle per event.
REQ-008 eval_ready  in  1  evaluator can accept the next scheduled evaluation.
REQ-009 q_push / q_pop  out  1 each  push requested / pop performed this cycle (combinational).
REQ-010 q_push_valid / q_pop_valid  out  1 each  push accepted / popped entry is real (combinational).
REQ-011 pacing_0..pacing_3  out  1 each  registered stream-activation bits for the evaluation in flight.
REQ-012 eval_valid  out  1  registered; pacing and eval_timestamp are valid this cycle.
REQ-013 eval_timestamp  out  TS_WIDTH  registered timestamp of the popped event.
REQ-014 overflow  out  1  sticky flag: an event was dropped because the queue was full.

Function
REQ-015 SHALL keep a free-running timestamp counter: +1 per enabled cycle, wraps 2^TS_WIDTH-1 -> 0.
REQ-016 SHALL keep a period counter 0..PERIOD_CYCLES-1; deadline = (counter == PERIOD_CYCLES-1) & en; the counter returns to 0 on the next edge.
REQ-017 q_push SHALL be en & (new_input_0 | new_input_1 | deadline).
REQ-018 Entry SHALL be {timestamp, m0=new_input_0, m1=new_input_1, p=deadline}; input strobes and a deadline in the same cycle merge into one entry.
REQ-019 Queue SHALL be FIFO of DEPTH entries with read/write pointers and an occupancy count 0..DEPTH.
REQ-020 q_pop SHALL be en & eval_ready & (count != 0); q_pop_valid SHALL equal q_pop.
REQ-021 q_push_valid SHALL be q_push & ((count < DEPTH) | q_pop); a push and a pop in the same cycle when full SHALL both succeed, with count unchanged.
REQ-022 Push and pop in the same cycle when empty: the entry is written, nothing is popped, and count becomes 1 (no bypass).
REQ-023 Rejected push (q_push & !q_push_valid) SHALL set overflow; overflow clears only on rst.
REQ-024 On the edge after q_pop, SHALL register pacing_0=m0, pacing_1=m1, pacing_2=m0&m1, pacing_3=p, eval_timestamp=entry timestamp, and eval_valid=1.
REQ-025 In cycles without q_pop, eval_valid and pacing_0..3 SHALL be 0 on the next edge; eval_timestamp holds its value.
REQ-026 Minimum latency from strobe (cycle t) to eval_valid SHALL be 2 cycles: entry visible at t+1, pop at t+1, eval_valid at t+2.
REQ-027 Order SHALL be strict FIFO; pointers wrap modulo DEPTH.
REQ-028 With en=0: counters, pointers, queue contents and overflow hold; eval_valid and pacing drop to 0 on the next edge.

Reset
REQ-029 While rst=1 at an edge: timestamp=0, period counter=0, pointers=0, count=0, overflow=0, eval_valid=0, pacing_0..3=0, eval_timestamp=0.
REQ-030 rst SHALL take priority over en and over any push/pop in the same cycle; queued entries are discarded.
REQ-031 Combinational outputs during rst SHALL still follow REQ-017/020/021, but no state changes.

Verification
REQ-032 Single event: after rst, eval_ready=1, strobe new_input_0 & new_input_1 at timestamp 10 -> 2 cycles later eval_valid=1, pacing=1110 (bits 0..3), eval_timestamp=10.
REQ-033 Periodic: PERIOD_CYCLES=8, no inputs -> deadline at timestamps 7 and 15; eval_valid with pacing=0001 at 9 and 17.
REQ-034 Merge: new_input_1 on a deadline cycle -> one entry; pacing=0101; single eval_valid pulse.
REQ-035 Overflow: DEPTH=4, eval_ready=0, 5 strobes -> q_push_valid=0 on the 5th strobe, overflow=1, count=4; then eval_ready=1 -> 4 evaluations in order.
REQ-036 Full push+pop: count=4, eval_ready=1, strobe -> q_push_valid=1, q_pop=1, count stays 4, overflow stays 0.
REQ-037 Reset mid-operation: count=3, rst for 1 cycle -> count=0, eval_valid=0, timestamp restarts at 0, overflow=0.

Source files
------------

// File: rtl/event_pacing_scheduler_if.sv
// rtl/event_pacing_scheduler_if.sv - strobe, evaluator handshake and status signals of the pacing scheduler
interface event_pacing_scheduler_if #(
  parameter int TS_WIDTH = 32
);
  logic                en;
  logic                new_input_0;
  logic                new_input_1;
  logic                eval_ready;
  logic                q_push;
  logic                q_pop;
  logic                q_push_valid;
  logic                q_pop_valid;
  logic                pacing_0;
  logic                pacing_1;
  logic                pacing_2;
  logic                pacing_3;
  logic                eval_valid;
  logic [TS_WIDTH-1:0] eval_timestamp;
  logic                overflow;

  modport slave (
    input  en, new_input_0, new_input_1, eval_ready,
    output q_push, q_pop, q_push_valid, q_pop_valid,
    output pacing_0, pacing_1, pacing_2, pacing_3,
    output eval_valid, eval_timestamp, overflow
  );

  modport master (
    output en, new_input_0, new_input_1, eval_ready,
    input  q_push, q_pop, q_push_valid, q_pop_valid,
    input  pacing_0, pacing_1, pacing_2, pacing_3,
    input  eval_valid, eval_timestamp, overflow
  );
endinterface

// File: rtl/event_pacing_scheduler.sv
// rtl/event_pacing_scheduler.sv - timestamps input strobes and periodic deadlines, queues them, and
// issues one paced evaluation per popped entry.
module event_pacing_scheduler #(
  parameter int PERIOD_CYCLES = 1000,
  parameter int DEPTH         = 4,
  parameter int TS_WIDTH      = 32
) (
  input logic                    clk,
  input logic                    rst,
  event_pacing_scheduler_if.slave bus
);
  localparam int PC_W  = $clog2(PERIOD_CYCLES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TS_WIDTH-1:0] ts;
  logic [PC_W-1:0]     period_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow_r;
  logic                eval_valid_r;
  logic [3:0]          pacing_r;
  logic [TS_WIDTH-1:0] eval_ts_r;

  // flags per entry are {p, m1, m0}
  logic [TS_WIDTH-1:0] mem_ts    [DEPTH];
  logic [2:0]          mem_flags [DEPTH];

  logic deadline;
  logic push;
  logic pop;
  logic push_ok;
  logic [2:0] head_flags;

  always_comb begin
    deadline   = bus.en & (period_cnt == PC_W'(PERIOD_CYCLES - 1));
    push       = bus.en & (bus.new_input_0 | bus.new_input_1 | deadline);
    pop        = bus.en & bus.eval_ready & (count != '0);
    push_ok    = push & ((count < CNT_W'(DEPTH)) | pop);
    head_flags = mem_flags[rd_ptr];
  end

  assign bus.q_push         = push;
  assign bus.q_pop          = pop;
  assign bus.q_push_valid   = push_ok;
  assign bus.q_pop_valid    = pop;
  assign bus.overflow       = overflow_r;
  assign bus.eval_valid     = eval_valid_r;
  assign bus.eval_timestamp = eval_ts_r;
  assign bus.pacing_0       = pacing_r[0];
  assign bus.pacing_1       = pacing_r[1];
  assign bus.pacing_2       = pacing_r[2];
  assign bus.pacing_3       = pacing_r[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      period_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else if (bus.en) begin
      ts         <= ts + 1'b1;
      period_cnt <= deadline ? '0 : period_cnt + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push & ~push_ok) overflow_r <= 1'b1;
    end
  end

  // Storage has no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_ts[wr_ptr]    <= ts;
      mem_flags[wr_ptr] <= {deadline, bus.new_input_1, bus.new_input_0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eval_valid_r <= 1'b0;
      pacing_r     <= 4'b0;
      eval_ts_r    <= '0;
    end else begin
      eval_valid_r <= pop;
      pacing_r     <= pop ? {head_flags[2], head_flags[0] & head_flags[1], head_flags[1], head_flags[0]}
                          : 4'b0;
      if (pop) eval_ts_r <= mem_ts[rd_ptr];
    end
  end
endmodule

// File: tb/tb_event_pacing_scheduler.sv
// tb/tb_event_pacing_scheduler.sv - randomized and directed checks of event_pacing_scheduler
// against a queue-based reference model.
module tb_event_pacing_scheduler;
  localparam int PERIOD = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    bit [31:0] ts;
    bit        m0;
    bit        m1;
    bit        p;
  } entry_t;

  logic clk;
  logic rst;
  event_pacing_scheduler_if #(.TS_WIDTH(32)) bus ();

  event_pacing_scheduler #(.PERIOD_CYCLES(PERIOD), .DEPTH(DEPTH), .TS_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  entry_t    m_q[$];
  bit [31:0] m_ts;
  bit        m_ovf;
  bit        m_ev;
  bit [3:0]  m_pac;
  bit [31:0] m_evts;

  bit exp_push, exp_pop, exp_pv;
  logic act_push, act_pop, act_pv, act_popv;

  function automatic logic [3:0] pac();
    return {bus.pacing_3, bus.pacing_2, bus.pacing_1, bus.pacing_0};
  endfunction

  // Drives one cycle, samples combinational outputs mid-cycle and advances the model at the edge.
  task automatic step(input bit r, input bit e, input bit a, input bit b, input bit er);
    bit     dl;
    entry_t ent;
    @(negedge clk);
    rst = r; bus.en = e; bus.new_input_0 = a; bus.new_input_1 = b; bus.eval_ready = er;
    #1;
    dl       = e && ((m_ts % PERIOD) == PERIOD - 1);
    exp_push = e && (a || b || dl);
    exp_pop  = e && er && (m_q.size() != 0);
    exp_pv   = exp_push && ((m_q.size() < DEPTH) || exp_pop);
    act_push = bus.q_push; act_pop = bus.q_pop; act_pv = bus.q_push_valid; act_popv = bus.q_pop_valid;
    @(posedge clk);
    if (r) begin
      m_ts = 0; m_q.delete(); m_ovf = 0; m_ev = 0; m_pac = 0; m_evts = 0;
    end else if (e) begin
      if (exp_pop) begin
        ent = m_q.pop_front();
        m_ev = 1; m_evts = ent.ts;
        m_pac = {ent.p, ent.m0 & ent.m1, ent.m1, ent.m0};
      end else begin
        m_ev = 0; m_pac = 0;
      end
      if (exp_pv) begin
        ent.ts = m_ts; ent.m0 = a; ent.m1 = b; ent.p = dl;
        m_q.push_back(ent);
      end
      if (exp_push && !exp_pv) m_ovf = 1;
      m_ts = m_ts + 1;
    end else begin
      m_ev = 0; m_pac = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    n_cmp++; if (act_push !== 1'b1) begin n_err++; $display("FAIL rst_q_push: got %b want 1", act_push); end
    n_cmp++; if (act_pop !== 1'b0) begin n_err++; $display("FAIL rst_q_pop: got %b want 0", act_pop); end
    n_cmp++; if (bus.eval_valid !== 1'b0) begin n_err++; $display("FAIL rst_eval_valid: got %b want 0", bus.eval_valid); end
    n_cmp++; if (pac() !== 4'b0) begin n_err++; $display("FAIL rst_pacing: got %b want 0000", pac()); end
    n_cmp++; if (bus.eval_timestamp !== 32'd0) begin n_err++; $display("FAIL rst_eval_ts: got %0d want 0", bus.eval_timestamp); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
    step(0, 1, 0, 0, 1);
    n_cmp++; if (act_pop !== 1'b0) begin n_err++; $display("FAIL rst_empty_after: got q_pop=%b want 0", act_pop); end
  endtask

  task automatic test_single_event();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_ts != 10; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 1);
    n_cmp++; if (act_pv !== 1'b1) begin n_err++; $display("FAIL single_push_valid: got %b want 1", act_pv); end
    n_cmp++; if (bus.eval_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got eval_valid=%b want 0", bus.eval_valid); end
    step(0, 1, 0, 0, 1);
    n_cmp++; if (act_pop !== 1'b1) begin n_err++; $display("FAIL single_pop_t1: got %b want 1", act_pop); end
    n_cmp++; if (bus.eval_valid !== 1'b1) begin n_err++; $display("FAIL single_eval_valid: got %b want 1", bus.eval_valid); end
    n_cmp++; if (pac() !== 4'b0111) begin n_err++; $display("FAIL single_pacing: got %b want 0111", pac()); end
    n_cmp++; if (bus.eval_timestamp !== 32'd10) begin n_err++; $display("FAIL single_eval_ts: got %0d want 10", bus.eval_timestamp); end
  endtask

  task automatic test_periodic();
    bit want;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 1);
      want = (m_ts == 9) || (m_ts == 17);
      n_cmp++; if (bus.eval_valid !== want) begin n_err++; $display("FAIL periodic_valid@%0d: got %b want %b", m_ts, bus.eval_valid, want); end
      if (want) begin
        n_cmp++; if (pac() !== 4'b1000) begin n_err++; $display("FAIL periodic_pacing@%0d: got %b want 1000", m_ts, pac()); end
        n_cmp++; if (bus.eval_timestamp !== m_ts - 2) begin n_err++; $display("FAIL periodic_ts: got %0d want %0d", bus.eval_timestamp, m_ts - 2); end
      end
    end
  endtask

  task automatic test_merge();
    int pulses;
    logic [3:0] got_pac;
    logic [31:0] got_ts;
    pulses = 0; got_pac = 'x; got_ts = 'x;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_ts != 7; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    n_cmp++; if (act_pv !== 1'b1) begin n_err++; $display("FAIL merge_push: got %b want 1", act_pv); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 1);
      if (bus.eval_valid === 1'b1) begin pulses++; got_pac = pac(); got_ts = bus.eval_timestamp; end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL merge_pulses: got %0d want 1", pulses); end
    n_cmp++; if (got_pac !== 4'b1010) begin n_err++; $display("FAIL merge_pacing: got %b want 1010", got_pac); end
    n_cmp++; if (got_ts !== 32'd7) begin n_err++; $display("FAIL merge_ts: got %0d want 7", got_ts); end
  endtask

  task automatic test_overflow();
    logic [31:0] got_ts[$];
    logic [3:0]  got_pac[$];
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0);
      n_cmp++; if (act_pv !== (i < 4)) begin n_err++; $display("FAIL ovf_push_valid[%0d]: got %b want %b", i, act_pv, i < 4); end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 1);
      if (bus.eval_valid === 1'b1) begin got_ts.push_back(bus.eval_timestamp); got_pac.push_back(pac()); end
    end
    n_cmp++;
    if (got_ts.size() < 4) begin
      n_err++; $display("FAIL ovf_drain_count: got %0d evaluations want at least 4", got_ts.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (got_ts[i] !== 32'(i) || got_pac[i] !== 4'b0001) begin
          n_err++; $display("FAIL ovf_order[%0d]: got ts=%0d pacing=%b want ts=%0d pacing=0001", i, got_ts[i], got_pac[i], i);
        end
      end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 1);
    n_cmp++; if (act_pv !== 1'b1) begin n_err++; $display("FAIL full_push_valid: got %b want 1", act_pv); end
    n_cmp++; if (act_pop !== 1'b1 || act_popv !== 1'b1) begin n_err++; $display("FAIL full_pop: got q_pop=%b q_pop_valid=%b want 1/1", act_pop, act_popv); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_overflow: got %b want 0", bus.overflow); end
    step(0, 1, 1, 0, 0);
    n_cmp++; if (act_pv !== 1'b0) begin n_err++; $display("FAIL full_still_full: got q_push_valid=%b want 0", act_pv); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1);
    step(1, 1, 1, 1, 1);
    n_cmp++; if (bus.eval_valid !== 1'b0) begin n_err++; $display("FAIL mid_eval_valid: got %b want 0", bus.eval_valid); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", bus.overflow); end
    step(0, 1, 1, 0, 1);
    n_cmp++; if (act_pop !== 1'b0) begin n_err++; $display("FAIL mid_count_zero: got q_pop=%b want 0", act_pop); end
    step(0, 1, 0, 0, 1);
    n_cmp++; if (bus.eval_valid !== 1'b1 || bus.eval_timestamp !== 32'd0) begin
      n_err++; $display("FAIL mid_ts_restart: got valid=%b ts=%0d want 1/0", bus.eval_valid, bus.eval_timestamp);
    end
  endtask

  task automatic test_enable();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1);
      n_cmp++; if (act_push !== 1'b0 || act_pop !== 1'b0) begin n_err++; $display("FAIL en_frozen[%0d]: got push=%b pop=%b want 0/0", i, act_push, act_pop); end
      n_cmp++; if (bus.eval_valid !== 1'b0) begin n_err++; $display("FAIL en_eval_valid[%0d]: got %b want 0", i, bus.eval_valid); end
    end
    step(0, 1, 0, 0, 1);
    n_cmp++; if (bus.eval_timestamp !== 32'd0) begin n_err++; $display("FAIL en_first: got %0d want 0", bus.eval_timestamp); end
    step(0, 1, 1, 0, 1);
    n_cmp++; if (bus.eval_timestamp !== 32'd1) begin n_err++; $display("FAIL en_second: got %0d want 1", bus.eval_timestamp); end
    step(0, 1, 0, 0, 1);
    n_cmp++; if (bus.eval_timestamp !== 32'd3) begin n_err++; $display("FAIL en_ts_held: got %0d want 3", bus.eval_timestamp); end
  endtask

  task automatic test_random();
    bit r, e, a, b, er;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) == 0);
      e  = ($urandom_range(9) != 0);
      a  = ($urandom_range(9) < 3);
      b  = ($urandom_range(9) < 3);
      er = ($urandom_range(1) == 1);
      step(r, e, a, b, er);
      n_cmp++; if (act_push !== exp_push) begin n_err++; $display("FAIL rnd_q_push[%0d]: got %b want %b", i, act_push, exp_push); end
      n_cmp++; if (act_pop !== exp_pop) begin n_err++; $display("FAIL rnd_q_pop[%0d]: got %b want %b", i, act_pop, exp_pop); end
      n_cmp++; if (act_pv !== exp_pv) begin n_err++; $display("FAIL rnd_q_push_valid[%0d]: got %b want %b", i, act_pv, exp_pv); end
      n_cmp++; if (act_popv !== exp_pop) begin n_err++; $display("FAIL rnd_q_pop_valid[%0d]: got %b want %b", i, act_popv, exp_pop); end
      n_cmp++; if (bus.eval_valid !== m_ev) begin n_err++; $display("FAIL rnd_eval_valid[%0d]: got %b want %b", i, bus.eval_valid, m_ev); end
      n_cmp++; if (pac() !== m_pac) begin n_err++; $display("FAIL rnd_pacing[%0d]: got %b want %b", i, pac(), m_pac); end
      n_cmp++; if (bus.eval_timestamp !== m_evts) begin n_err++; $display("FAIL rnd_eval_ts[%0d]: got %0d want %0d", i, bus.eval_timestamp, m_evts); end
      n_cmp++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow[%0d]: got %b want %b", i, bus.overflow, m_ovf); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_ts = 0; m_ovf = 0; m_ev = 0; m_pac = 0; m_evts = 0;
    rst = 1'b1; bus.en = 1'b0; bus.new_input_0 = 1'b0; bus.new_input_1 = 1'b0; bus.eval_ready = 1'b0;
    test_reset();
    test_single_event();
    test_periodic();
    test_merge();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
